// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: ALU operation codes, ALUOp/funct
// encodings and the control bundle carried between pipeline registers.
package mips_pkg;

    // ALU operation select
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    // ALUOp from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // R-type function field
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Control bundle that travels down the pipe with an instruction
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
        logic alu_src;
    } ctrl_t;

endpackage

// File: rtl/alu_control.sv
// ALU control decode: (ALUOp, funct) -> 4-bit operation plus an illegal flag.
// Purely combinational so the instruction decoder can share it.
module alu_control import mips_pkg::*; (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] operation,
    output logic       illegal
);

    // Unknown ALUOp or funct maps to the NOP operation and flags illegal.
    always_comb begin
        operation = ALU_NOP;
        illegal   = 1'b0;
        case (alu_op)
            ALUOP_ADD: operation = ALU_ADD;
            ALUOP_SUB: operation = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:  operation = ALU_ADD;
                    FN_SUB:  operation = ALU_SUB;
                    FN_AND:  operation = ALU_AND;
                    FN_OR:   operation = ALU_OR;
                    FN_SLT:  operation = ALU_SLT;
                    default: illegal   = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, EX-side operand
// forwarding and load-use hazard detection. Drives the ALU directly.
module id_ex_stage import mips_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              flush,
    input  logic              fwd_em_we,
    input  logic [REG_AW-1:0] fwd_em_rd,
    input  logic [DATA_W-1:0] fwd_em_data,
    input  logic              fwd_mw_we,
    input  logic [REG_AW-1:0] fwd_mw_rd,
    input  logic [DATA_W-1:0] fwd_mw_data,
    output logic              load_use_stall,
    output logic [DATA_W-1:0] ex_number1,
    output logic [DATA_W-1:0] ex_number2,
    output logic [3:0]        ex_operation,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic [DATA_W-1:0] ex_branch_target,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic              ex_illegal
);

    ctrl_t             id_ctrl;
    ctrl_t             ex_ctrl;
    logic [3:0]        dec_operation;
    logic              dec_illegal;
    logic              capture;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    alu_control u_alu_control (
        .alu_op    (id_alu_op),
        .funct     (id_funct),
        .operation (dec_operation),
        .illegal   (dec_illegal)
    );

    // Illegal decodes never write the register file or memory.
    always_comb begin
        id_ctrl            = '0;
        id_ctrl.reg_write  = id_reg_write & ~dec_illegal;
        id_ctrl.mem_read   = id_mem_read;
        id_ctrl.mem_write  = id_mem_write & ~dec_illegal;
        id_ctrl.mem_to_reg = id_mem_to_reg;
        id_ctrl.branch     = id_branch;
        id_ctrl.alu_src    = id_alu_src;
    end

    // Load in EX whose destination is read by ID; rt is checked even for I-type.
    always_comb begin
        load_use_stall = ex_valid & ex_ctrl.mem_read & (ex_dest != '0) & id_valid &
                         ((id_rs == ex_dest) | (id_rt == ex_dest));
        capture        = id_valid & ~flush & ~load_use_stall;
    end

    // Pipeline register: capture a real instruction, otherwise load a zeroed bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid         <= 1'b0;
            ex_ctrl          <= '0;
            ex_operation     <= ALU_AND;
            ex_illegal       <= 1'b0;
            ex_dest          <= '0;
            ex_rs            <= '0;
            ex_rt            <= '0;
            rs_q             <= '0;
            rt_q             <= '0;
            imm_q            <= '0;
            ex_branch_target <= '0;
        end else if (capture) begin
            ex_valid         <= 1'b1;
            ex_ctrl          <= id_ctrl;
            ex_operation     <= dec_operation;
            ex_illegal       <= dec_illegal;
            ex_dest          <= id_reg_dst ? id_rd : id_rt;
            ex_rs            <= id_rs;
            ex_rt            <= id_rt;
            rs_q             <= id_rs_data;
            rt_q             <= id_rt_data;
            imm_q            <= id_imm;
            ex_branch_target <= id_pc_plus4 + (id_imm << 2);
        end else begin
            ex_valid         <= 1'b0;
            ex_ctrl          <= '0;
            ex_operation     <= ALU_AND;
            ex_illegal       <= 1'b0;
            ex_dest          <= '0;
            ex_rs            <= '0;
            ex_rt            <= '0;
            rs_q             <= '0;
            rt_q             <= '0;
            imm_q            <= '0;
            ex_branch_target <= '0;
        end
    end

    // Operand forwarding: EX/MEM beats MEM/WB, register 0 is never forwarded.
    always_comb begin
        fwd_rs = rs_q;
        if (fwd_mw_we && (fwd_mw_rd == ex_rs) && (ex_rs != '0)) fwd_rs = fwd_mw_data;
        if (fwd_em_we && (fwd_em_rd == ex_rs) && (ex_rs != '0)) fwd_rs = fwd_em_data;
        fwd_rt = rt_q;
        if (fwd_mw_we && (fwd_mw_rd == ex_rt) && (ex_rt != '0)) fwd_rt = fwd_mw_data;
        if (fwd_em_we && (fwd_em_rd == ex_rt) && (ex_rt != '0)) fwd_rt = fwd_em_data;
    end

    assign ex_number1    = fwd_rs;
    assign ex_number2    = ex_ctrl.alu_src ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_branch     = ex_ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written hazard
// sequences, and randomized traffic against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc_plus4;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read;
    logic        id_mem_write, id_mem_to_reg, id_branch, flush;
    logic        fwd_em_we, fwd_mw_we;
    logic [4:0]  fwd_em_rd, fwd_mw_rd;
    logic [31:0] fwd_em_data, fwd_mw_data;
    logic        load_use_stall;
    logic [31:0] ex_number1, ex_number2, ex_store_data, ex_branch_target;
    logic [3:0]  ex_operation;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_mem_to_reg, ex_branch, ex_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_pc_plus4(id_pc_plus4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .flush(flush), .fwd_em_we(fwd_em_we), .fwd_em_rd(fwd_em_rd), .fwd_em_data(fwd_em_data),
        .fwd_mw_we(fwd_mw_we), .fwd_mw_rd(fwd_mw_rd), .fwd_mw_data(fwd_mw_data),
        .load_use_stall(load_use_stall), .ex_number1(ex_number1), .ex_number2(ex_number2),
        .ex_operation(ex_operation), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_branch_target(ex_branch_target), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic [1:0]  aop;
        logic [5:0]  fn;
        logic        src;
        logic [4:0]  rs;
        logic [31:0] rsd, rtd, imm, pc;
        logic        em_we, mw_we;
        logic [4:0]  frd;
        logic [31:0] emd, mwd;
        logic [31:0] e_n1, e_n2, e_sd;
        logic [3:0]  e_op;
        logic        e_ill, e_rw;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t tv[15];

    function automatic vec_t mk(string nm, logic [1:0] aop, logic [5:0] fn, logic src,
                                logic [4:0] rs, logic [31:0] rsd, logic [31:0] rtd,
                                logic [31:0] imm, logic [31:0] pc, logic emwe, logic mwwe,
                                logic [4:0] frd, logic [31:0] emd, logic [31:0] mwd,
                                logic [31:0] n1, logic [31:0] n2, logic [31:0] sd,
                                logic [3:0] op, logic ill, logic rw, logic [31:0] tgt);
        vec_t v;
        v.name = nm; v.aop = aop; v.fn = fn; v.src = src; v.rs = rs; v.rsd = rsd; v.rtd = rtd;
        v.imm = imm; v.pc = pc; v.em_we = emwe; v.mw_we = mwwe; v.frd = frd; v.emd = emd;
        v.mwd = mwd; v.e_n1 = n1; v.e_n2 = n2; v.e_sd = sd; v.e_op = op; v.e_ill = ill;
        v.e_rw = rw; v.e_tgt = tgt;
        return v;
    endfunction

    task automatic drive(input logic v, input logic [1:0] aop, input logic [5:0] fn,
                         input logic src, input logic rdst, input logic rw, input logic mr,
                         input logic mw, input logic m2r, input logic br, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [31:0] imm, input logic [31:0] pc);
        id_valid = v; id_alu_op = aop; id_funct = fn; id_alu_src = src; id_reg_dst = rdst;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
        id_branch = br; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd;
        id_rt_data = rtd; id_imm = imm; id_pc_plus4 = pc;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic        ill, rw, mr, mw, m2r, br, src;
        logic [4:0]  rs, rt, dest;
        logic [31:0] rsd, rtd, imm, tgt;
    } m_t;

    m_t m;

    function automatic m_t bubble();
        m_t b;
        b.v = 0; b.op = 0; b.ill = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.m2r = 0; b.br = 0;
        b.src = 0; b.rs = 0; b.rt = 0; b.dest = 0; b.rsd = 0; b.rtd = 0; b.imm = 0; b.tgt = 0;
        return b;
    endfunction

    // Returns {illegal, operation} from the decode table.
    function automatic logic [4:0] ref_dec(input logic [1:0] aop, input logic [5:0] fn);
        if (aop == 2'd0) return {1'b0, 4'd2};
        if (aop == 2'd1) return {1'b0, 4'd6};
        if (aop == 2'd2) begin
            if (fn == 6'd32) return {1'b0, 4'd2};
            if (fn == 6'd34) return {1'b0, 4'd6};
            if (fn == 6'd36) return {1'b0, 4'd0};
            if (fn == 6'd37) return {1'b0, 4'd1};
            if (fn == 6'd42) return {1'b0, 4'd7};
        end
        return {1'b1, 4'd15};
    endfunction

    function automatic m_t ref_capture();
        m_t c;
        logic [4:0] d;
        d = ref_dec(id_alu_op, id_funct);
        c.v = 1; c.ill = d[4]; c.op = d[3:0];
        c.rw = id_reg_write && !c.ill; c.mw = id_mem_write && !c.ill;
        c.mr = id_mem_read; c.m2r = id_mem_to_reg; c.br = id_branch; c.src = id_alu_src;
        c.rs = id_rs; c.rt = id_rt; c.dest = id_reg_dst ? id_rd : id_rt;
        c.rsd = id_rs_data; c.rtd = id_rt_data; c.imm = id_imm;
        c.tgt = id_pc_plus4 + id_imm * 4;
        return c;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] regv);
        if (r == 0) return regv;
        if (fwd_em_we && fwd_em_rd == r) return fwd_em_data;
        if (fwd_mw_we && fwd_mw_rd == r) return fwd_mw_data;
        return regv;
    endfunction

    function automatic logic ref_stall();
        return m.v && m.mr && m.dest != 0 && id_valid && (id_rs == m.dest || id_rt == m.dest);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_n1"}, ex_number1, ref_fwd(m.rs, m.rsd));
        chk({tag, "_n2"}, ex_number2, m.src ? m.imm : ref_fwd(m.rt, m.rtd));
        chk({tag, "_sd"}, ex_store_data, ref_fwd(m.rt, m.rtd));
        chk({tag, "_op"}, {28'd0, ex_operation}, {28'd0, m.op});
        chk({tag, "_dest"}, {27'd0, ex_dest}, {27'd0, m.dest});
        chk({tag, "_tgt"}, ex_branch_target, m.tgt);
        chk({tag, "_ctl"},
            {25'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal},
            {25'd0, m.v, m.rw, m.mr, m.mw, m.m2r, m.br, m.ill});
    endtask

    initial begin
        rst = 1; flush = 0;
        fwd_em_we = 0; fwd_mw_we = 0; fwd_em_rd = 0; fwd_mw_rd = 0; fwd_em_data = 0; fwd_mw_data = 0;

        //            name      aop fn     src rs rsd rtd imm          pc           em mw frd emd    mwd    n1     n2           sd     op    ill rw tgt
        tv[0]  = mk("add",      2, 6'h20, 0, 1, 5, 7, 0,           0,           0, 0, 0, 0,     0,     5,     7,           7,     4'h2, 0, 1, 0);
        tv[1]  = mk("sub",      2, 6'h22, 0, 1, 5, 7, 0,           0,           0, 0, 0, 0,     0,     5,     7,           7,     4'h6, 0, 1, 0);
        tv[2]  = mk("and",      2, 6'h24, 0, 1, 5, 7, 0,           0,           0, 0, 0, 0,     0,     5,     7,           7,     4'h0, 0, 1, 0);
        tv[3]  = mk("or",       2, 6'h25, 0, 1, 5, 7, 0,           0,           0, 0, 0, 0,     0,     5,     7,           7,     4'h1, 0, 1, 0);
        tv[4]  = mk("slt",      2, 6'h2a, 0, 1, 5, 7, 0,           0,           0, 0, 0, 0,     0,     5,     7,           7,     4'h7, 0, 1, 0);
        tv[5]  = mk("aop01",    1, 6'h00, 0, 1, 5, 7, 0,           0,           0, 0, 0, 0,     0,     5,     7,           7,     4'h6, 0, 1, 0);
        tv[6]  = mk("aop00",    0, 6'h00, 0, 1, 5, 7, 0,           0,           0, 0, 0, 0,     0,     5,     7,           7,     4'h2, 0, 1, 0);
        tv[7]  = mk("ill_fn",   2, 6'h00, 0, 1, 5, 7, 0,           0,           0, 0, 0, 0,     0,     5,     7,           7,     4'hF, 1, 0, 0);
        tv[8]  = mk("ill_aop",  3, 6'h20, 0, 1, 5, 7, 0,           0,           0, 0, 0, 0,     0,     5,     7,           7,     4'hF, 1, 0, 0);
        tv[9]  = mk("fwd_em",   2, 6'h20, 0, 3, 5, 7, 0,           0,           1, 1, 3, 32'hAA, 32'hBB, 32'hAA, 7,           7,     4'h2, 0, 1, 0);
        tv[10] = mk("fwd_mw",   2, 6'h20, 0, 3, 5, 7, 0,           0,           0, 1, 3, 32'hAA, 32'hBB, 32'hBB, 7,           7,     4'h2, 0, 1, 0);
        tv[11] = mk("fwd_r0",   2, 6'h20, 0, 0, 5, 7, 0,           0,           1, 1, 0, 32'hAA, 32'hBB, 5,     7,           7,     4'h2, 0, 1, 0);
        tv[12] = mk("fwd_rt",   0, 6'h00, 1, 1, 5, 7, 9,           0,           1, 0, 2, 32'h11, 0,     5,     9,           32'h11, 4'h2, 0, 1, 32'h24);
        tv[13] = mk("br_neg",   0, 6'h00, 1, 1, 5, 7, 32'hFFFFFFFF, 32'h100,     0, 0, 0, 0,     0,     5,     32'hFFFFFFFF, 7,     4'h2, 0, 1, 32'hFC);
        tv[14] = mk("br_wrap",  0, 6'h00, 1, 1, 5, 7, 1,           32'hFFFFFFFC, 0, 0, 0, 0,     0,     5,     1,           7,     4'h2, 0, 1, 0);

        // Reset: hold across two edges with a live instruction presented.
        drive(1, 2, 6'h20, 0, 1, 1, 0, 0, 0, 0, 1, 2, 4, 5, 7, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_op", ex_operation, 0);
        chk("rst_n1", ex_number1, 0);
        chk("rst_n2", ex_number2, 0);
        chk("rst_sd", ex_store_data, 0);
        chk("rst_tgt", ex_branch_target, 0);
        chk("rst_dest", ex_dest, 0);
        chk("rst_ctl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal}, 0);
        chk("rst_stall", load_use_stall, 0);
        @(negedge clk);
        rst = 0;

        // Table: present at negedge, capture at posedge, then apply forwarding and check.
        for (int i = 0; i < 15; i++) begin
            fwd_em_we = 0; fwd_mw_we = 0;
            drive(1, tv[i].aop, tv[i].fn, tv[i].src, 1, 1, 0, 0, 0, 0, tv[i].rs, 2, 4,
                  tv[i].rsd, tv[i].rtd, tv[i].imm, tv[i].pc);
            @(posedge clk);
            #1;
            fwd_em_we = tv[i].em_we; fwd_mw_we = tv[i].mw_we;
            fwd_em_rd = tv[i].frd; fwd_mw_rd = tv[i].frd;
            fwd_em_data = tv[i].emd; fwd_mw_data = tv[i].mwd;
            #1;
            chk({tv[i].name, "_n1"}, ex_number1, tv[i].e_n1);
            chk({tv[i].name, "_n2"}, ex_number2, tv[i].e_n2);
            chk({tv[i].name, "_sd"}, ex_store_data, tv[i].e_sd);
            chk({tv[i].name, "_op"}, ex_operation, tv[i].e_op);
            chk({tv[i].name, "_ill"}, ex_illegal, tv[i].e_ill);
            chk({tv[i].name, "_rw"}, ex_reg_write, tv[i].e_rw);
            chk({tv[i].name, "_tgt"}, ex_branch_target, tv[i].e_tgt);
            chk({tv[i].name, "_valid"}, ex_valid, 1);
            chk({tv[i].name, "_dest"}, ex_dest, 4);
            @(negedge clk);
        end
        fwd_em_we = 0; fwd_mw_we = 0;

        // Load-use: lw $8 in EX, add reading $8 in ID -> one bubble, then capture.
        drive(1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 8, 0, 0, 0, 4, 0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 2, 6'h20, 0, 1, 1, 0, 0, 0, 0, 8, 9, 10, 3, 4, 0, 0);
        #1;
        chk("lu_stall", load_use_stall, 1);
        @(posedge clk);
        #1;
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_rw", ex_reg_write, 0);
        chk("lu_stall_clear", load_use_stall, 0);
        @(posedge clk);
        #1;
        chk("lu_held_valid", ex_valid, 1);
        chk("lu_held_dest", ex_dest, 10);
        chk("lu_held_op", ex_operation, 4'h2);

        // Flush during stall: sw reading $8 behind lw $8, flush high -> single bubble.
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 8, 0, 0, 0, 4, 0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8, 3, 0, 0, 32'h55, 8, 0);
        flush = 1;
        #1;
        chk("fl_stall", load_use_stall, 1);
        @(posedge clk);
        #1;
        chk("fl_valid", ex_valid, 0);
        chk("fl_mw", ex_mem_write, 0);
        @(negedge clk);
        flush = 0;
        @(posedge clk);
        #1;
        chk("fl_next_valid", ex_valid, 1);
        chk("fl_next_mw", ex_mem_write, 1);
        chk("fl_next_sd", ex_store_data, 32'h55);

        // Randomized traffic against the model; registers drawn from a small set for hits.
        @(negedge clk);
        rst = 1;
        #1;
        rst = 0;
        m = bubble();
        for (int i = 0; i < 400; i++) begin
            begin
                logic [5:0] fns[6];
                fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2a;
                fns[5] = 6'($urandom);
                drive(($urandom_range(0, 7) != 0), 2'($urandom), fns[$urandom_range(0, 5)],
                      1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                      1'($urandom), 1'($urandom), 1'($urandom),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      $urandom, $urandom, $urandom, $urandom);
            end
            flush       = ($urandom_range(0, 7) == 0);
            fwd_em_we   = 1'($urandom);
            fwd_mw_we   = 1'($urandom);
            fwd_em_rd   = 5'($urandom_range(0, 3));
            fwd_mw_rd   = 5'($urandom_range(0, 3));
            fwd_em_data = $urandom;
            fwd_mw_data = $urandom;
            #1;
            chk("rnd_stall", load_use_stall, ref_stall());
            if (!flush && !ref_stall() && id_valid) m = ref_capture();
            else m = bubble();
            @(negedge clk);
            check_model("rnd");
            if (i == 200) begin
                rst = 1;
                #1;
                chk("mid_rst_valid", ex_valid, 0);
                chk("mid_rst_tgt", ex_branch_target, 0);
                rst = 0;
                m = bubble();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
